// File: rtl/hilo_ctrl.sv
// hilo_ctrl: execute-stage HI/LO controller that issues mult/div to MulDivUnit and commits results
module hilo_ctrl #(
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic             req_sign,
  input  logic [31:0]      req_rs,
  input  logic [31:0]      req_rt,
  input  logic             req_kill,
  output logic             stall,
  output logic [31:0]      rd_data,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic             busy,
  output logic [LAT_W-1:0] last_lat,
  output logic [31:0]      md_in_src0,
  output logic [31:0]      md_in_src1,
  output logic [1:0]       md_in_op,
  output logic             md_in_sign,
  output logic             md_in_valid,
  input  logic             md_in_ready,
  output logic             md_out_ready,
  input  logic             md_out_valid,
  input  logic [31:0]      md_out_res0,
  input  logic [31:0]      md_out_res1
);
  localparam logic [2:0] OP_MULT = 3'd1, OP_DIV = 3'd2, OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4, OP_MFHI = 3'd5, OP_MFLO = 3'd6;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_nxt;
  logic             live;
  logic             accept;
  logic             issue;
  assign live    = req_valid & ~req_kill & (req_op != 3'd0) & (req_op != 3'd7);
  assign busy    = state != IDLE;
  assign stall   = live & busy;
  assign accept  = live & ~busy;
  assign issue   = (req_op == OP_MULT) | ((req_op == OP_DIV) & (req_rt != 32'd0));
  assign cnt_nxt = (&cnt) ? cnt : cnt + LAT_W'(1);
  assign rd_data = (req_op == OP_MFHI) ? hi : (req_op == OP_MFLO) ? lo : 32'd0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      last_lat     <= '0;
      md_in_src0   <= '0;
      md_in_src1   <= '0;
      md_in_op     <= '0;
      md_in_sign   <= 1'b0;
      md_in_valid  <= 1'b0;
      md_out_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (issue) begin
            md_in_src0  <= req_rs;
            md_in_src1  <= req_rt;
            md_in_op    <= (req_op == OP_MULT) ? 2'b01 : 2'b10;
            md_in_sign  <= req_sign;
            md_in_valid <= 1'b1;
            cnt         <= LAT_W'(1);
            state       <= ISSUE;
          end
          if (req_op == OP_MTHI) hi <= req_rs;
          if (req_op == OP_MTLO) lo <= req_rs;
        end
        ISSUE: begin
          cnt <= cnt_nxt;
          if (md_in_ready) begin
            md_in_valid  <= 1'b0;
            md_out_ready <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (md_out_valid) begin
            hi           <= md_out_res1;
            lo           <= md_out_res0;
            last_lat     <= cnt;
            md_out_ready <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and randomized checks of hilo_ctrl against an arithmetic reference model
module tb_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic        req_sign = 1'b0;
  logic [31:0] req_rs = '0;
  logic [31:0] req_rt = '0;
  logic        req_kill = 1'b0;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic [7:0]  last_lat;
  logic [31:0] md_in_src0;
  logic [31:0] md_in_src1;
  logic [1:0]  md_in_op;
  logic        md_in_sign;
  logic        md_in_valid;
  logic        md_in_ready = 1'b0;
  logic        md_out_ready;
  logic        md_out_valid = 1'b0;
  logic [31:0] md_out_res0 = '0;
  logic [31:0] md_out_res1 = '0;

  hilo_ctrl #(.LAT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_sign(req_sign),
    .req_rs(req_rs), .req_rt(req_rt), .req_kill(req_kill), .stall(stall), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .last_lat(last_lat), .md_in_src0(md_in_src0),
    .md_in_src1(md_in_src1), .md_in_op(md_in_op), .md_in_sign(md_in_sign),
    .md_in_valid(md_in_valid), .md_in_ready(md_in_ready), .md_out_ready(md_out_ready),
    .md_out_valid(md_out_valid), .md_out_res0(md_out_res0), .md_out_res1(md_out_res1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Stand-in for both the MulDivUnit and the architectural expectation: plain 64-bit arithmetic.
  function automatic void ref_md(input bit is_div, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r_hi,
                                 output logic [31:0] r_lo);
    longint x, y, p, q;
    x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      p = x * y;
      r_hi = p[63:32];
      r_lo = p[31:0];
    end else begin
      p = x / y;
      q = x % y;
      r_lo = p[31:0];
      r_hi = q[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input bit sgn, input logic [31:0] rs,
                       input logic [31:0] rt, input bit kill);
    req_valid = 1'b1;
    req_op = op;
    req_sign = sgn;
    req_rs = rs;
    req_rt = rt;
    req_kill = kill;
  endtask

  task automatic run_md(input logic [2:0] op, input bit sgn, input logic [31:0] rs,
                        input logic [31:0] rt, input int din, input int dout, input string tag);
    logic [31:0] e_hi, e_lo, m_hi, m_lo;
    int lat;
    ref_md(op == 3'd2, sgn, rs, rt, e_hi, e_lo);
    lat = (din + dout + 2 > 255) ? 255 : din + dout + 2;
    drive(op, sgn, rs, rt, 1'b0);
    #1 chk({tag, ".accept_stall"}, stall, 0);
    tick();
    req_op = 3'd7;
    #1 chk({tag, ".op7_no_stall"}, stall, 0);
    req_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".in_valid"}, md_in_valid, 1);
    chk({tag, ".src0"}, md_in_src0, rs);
    chk({tag, ".src1"}, md_in_src1, rt);
    chk({tag, ".op"}, md_in_op, (op == 3'd1) ? 2'b01 : 2'b10);
    chk({tag, ".sign"}, md_in_sign, sgn);
    chk({tag, ".out_ready_issue"}, md_out_ready, 0);
    for (int i = 0; i < din; i++) begin
      tick();
      if (i < 4) begin
        chk({tag, ".hold_valid"}, md_in_valid, 1);
        chk({tag, ".hold_src0"}, md_in_src0, rs);
        chk({tag, ".hold_src1"}, md_in_src1, rt);
      end
    end
    ref_md(md_in_op == 2'b10, md_in_sign, md_in_src0, md_in_src1, m_hi, m_lo);
    md_in_ready = 1'b1;
    tick();
    md_in_ready = 1'b0;
    #1 chk({tag, ".valid_drop"}, md_in_valid, 0);
    chk({tag, ".out_ready"}, md_out_ready, 1);
    repeat (dout) tick();
    md_out_valid = 1'b1;
    md_out_res0 = m_lo;
    md_out_res1 = m_hi;
    drive(3'd5, 1'b0, '0, '0, 1'b0);
    #1 chk({tag, ".stall_mfhi"}, stall, 1);
    chk({tag, ".rd_old_hi"}, rd_data, exp_hi);
    tick();
    md_out_valid = 1'b0;
    md_out_res0 = $urandom;
    md_out_res1 = $urandom;
    #1 chk({tag, ".idle"}, busy, 0);
    chk({tag, ".no_stall"}, stall, 0);
    chk({tag, ".hi"}, hi, e_hi);
    chk({tag, ".lo"}, lo, e_lo);
    chk({tag, ".rd_new_hi"}, rd_data, e_hi);
    chk({tag, ".last_lat"}, last_lat, lat);
    chk({tag, ".out_ready_off"}, md_out_ready, 0);
    req_valid = 1'b0;
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    bit sg;
    repeat (2) @(posedge clk);
    #1 chk("rst.busy", busy, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.last_lat", last_lat, 0);
    chk("rst.in_valid", md_in_valid, 0);
    chk("rst.out_ready", md_out_ready, 0);
    chk("rst.src0", md_in_src0, 0);
    reset = 1'b1;
    tick();
    run_md(3'd1, 1'b1, 32'hFFFFFFFE, 32'h00000003, 0, 1, "mult_s");
    chk("mult_s.hi_const", hi, 32'hFFFFFFFF);
    chk("mult_s.lo_const", lo, 32'hFFFFFFFA);
    run_md(3'd2, 1'b0, 32'd7, 32'd2, 1, 0, "div_u");
    chk("div_u.lo_const", lo, 32'd3);
    chk("div_u.hi_const", hi, 32'd1);
    run_md(3'd2, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 0, "div_s");
    chk("div_s.lo_const", lo, 32'hFFFFFFFD);
    chk("div_s.hi_const", hi, 32'hFFFFFFFF);
    drive(3'd3, 1'b0, 32'h12345678, '0, 1'b0);
    tick();
    exp_hi = 32'h12345678;
    drive(3'd5, 1'b0, '0, '0, 1'b0);
    #1 chk("mthi.rd", rd_data, 32'h12345678);
    chk("mthi.lo_kept", lo, exp_lo);
    drive(3'd2, 1'b1, 32'd5, 32'd0, 1'b0);
    tick();
    #1 chk("div0.no_valid", md_in_valid, 0);
    chk("div0.busy", busy, 0);
    chk("div0.hi", hi, exp_hi);
    chk("div0.lo", lo, exp_lo);
    req_valid = 1'b0;
    md_out_valid = 1'b1;
    tick();
    md_out_valid = 1'b0;
    chk("stray_out.hi", hi, exp_hi);
    chk("stray_out.busy", busy, 0);
    run_md(3'd1, 1'b0, $urandom, $urandom, 3, 2, "hold");
    drive(3'd1, 1'b1, 32'd9, 32'd9, 1'b1);
    #1 chk("kill.stall", stall, 0);
    tick();
    chk("kill.busy", busy, 0);
    chk("kill.in_valid", md_in_valid, 0);
    drive(3'd4, 1'b0, 32'hDEADBEEF, '0, 1'b1);
    tick();
    chk("kill_mtlo.lo", lo, exp_lo);
    req_kill = 1'b0;
    req_valid = 1'b0;
    run_md(3'd1, 1'b1, $urandom, $urandom, 300, 10, "sat");
    drive(3'd2, 1'b0, 32'd100, 32'd7, 1'b0);
    tick();
    req_valid = 1'b0;
    md_in_ready = 1'b1;
    tick();
    md_in_ready = 1'b0;
    #1 chk("rstw.in_wait", md_out_ready, 1);
    reset = 1'b0;
    #1 chk("rstw.busy", busy, 0);
    chk("rstw.hi", hi, 0);
    chk("rstw.lo", lo, 0);
    chk("rstw.last_lat", last_lat, 0);
    chk("rstw.in_valid", md_in_valid, 0);
    chk("rstw.out_ready", md_out_ready, 0);
    chk("rstw.src0", md_in_src0, 0);
    chk("rstw.op", md_in_op, 0);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = $urandom;
      sg = 1'($urandom_range(0, 1));
      if (op == 3'd2) begin
        if (b == 0) b = 32'd1;
        if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      end
      if (op == 3'd1 || op == 3'd2)
        run_md(op, sg, a, b, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_md");
      else if (op == 3'd3 || op == 3'd4) begin
        drive(op, sg, a, b, 1'b0);
        tick();
        if (op == 3'd3) exp_hi = a; else exp_lo = a;
        chk("rnd_mt.hi", hi, exp_hi);
        chk("rnd_mt.lo", lo, exp_lo);
      end else begin
        drive(op, sg, a, b, 1'b0);
        #1 chk("rnd_mf.rd", rd_data, (op == 3'd5) ? exp_hi : exp_lo);
        chk("rnd_mf.stall", stall, 0);
        tick();
      end
      req_valid = 1'b0;
      req_op = 3'd0;
      #1 chk("rnd.nop_rd", rd_data, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
